// File: rtl/scan_chain_loader.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_loader
// Description : Serial loader for a configuration scan chain built from scff
//               cells. Parallel configuration words arrive on a valid/ready
//               stream and are shifted into the chain LSB first. Exactly
//               CHAIN_LEN bits are clocked in per load; when CHAIN_LEN is not
//               a multiple of WORD_W, only the low bits of the final word are
//               used. The chain clock enable is high only on shift cycles.
//
// Optional    : `define SCAN_READBACK_EN to reassemble the bits leaving the
//               chain tail into readback words on o_rb_data/o_rb_valid. With
//               the macro undefined, both readback outputs are tied to 0.
//
// Parameters  : CHAIN_LEN - number of scan cells in the chain (>= 1)
//               WORD_W    - configuration word width (>= 2)
//
// Ports       : i_clk          clock, shared with the chain clock-gate source
//               i_rst_n        asynchronous active-low reset
//               i_start        one-cycle load request, honoured only when idle
//               i_abort        terminate the load in progress
//               i_cfg_data     configuration word, bit 0 shifted first
//               i_cfg_valid    i_cfg_data valid
//               o_cfg_ready    word accepted when i_cfg_valid && o_cfg_ready
//               i_scan_so      chain tail output (last cell Q)
//               o_scan_en      shift-enable to every cell (1 = take SI)
//               o_scan_si      serial data into the chain head
//               o_scan_clk_en  chain clock-gate enable
//               o_busy         load in progress
//               o_done         one-cycle pulse on successful completion
//               o_err          sticky abort flag, cleared by an accepted start
//               o_rb_data      readback word
//               o_rb_valid     one-cycle readback strobe
//
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [WORD_W-1:0] i_cfg_data,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic              i_scan_so,
    output logic              o_scan_en,
    output logic              o_scan_si,
    output logic              o_scan_clk_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [WORD_W-1:0] o_rb_data,
    output logic              o_rb_valid
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BL_W = $clog2(CHAIN_LEN + 1);  // bits_left counter width
    localparam int c_WB_W = $clog2(WORD_W + 1);     // word_bits counter width

    localparam logic [c_BL_W-1:0] c_BITS_INIT = c_BL_W'(CHAIN_LEN);
    localparam logic [c_BL_W-1:0] c_BL_ONE    = c_BL_W'(1);
    localparam logic [c_WB_W-1:0] c_WB_ONE    = c_WB_W'(1);
    localparam logic [c_WB_W-1:0] c_WB_FULL   = c_WB_W'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_BL_W-1:0]   r_bits_left;
    logic [c_WB_W-1:0]   r_word_bits;
    logic [WORD_W-1:0]   r_shreg;
    logic                r_cfg_ready;
    logic                r_scan_en;
    logic                r_scan_clk_en;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic                w_handshake;
    logic                w_last_bit;
    logic                w_word_end;
    logic [c_WB_W-1:0]   w_word_bits_init;

    assign w_handshake = (r_state == S_LOAD) && i_cfg_valid && r_cfg_ready;
    assign w_last_bit  = (r_bits_left == c_BL_ONE);
    assign w_word_end  = (r_word_bits == c_WB_ONE);

    // Number of bits to take from the word being accepted: a full word, or
    // only what the chain still needs for the final partial word.
    always_comb begin
        if (32'(r_bits_left) >= WORD_W) begin
            w_word_bits_init = c_WB_FULL;
        end else begin
            w_word_bits_init = c_WB_W'(r_bits_left);
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // The shift register is kept at zero outside SHIFT (a full word has been
    // shifted out completely, and the partial-word / abort exits clear it), so
    // its LSB can drive the chain head directly from a flop.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_bits_left   <= '0;
            r_word_bits   <= '0;
            r_shreg       <= '0;
            r_cfg_ready   <= 1'b0;
            r_scan_en     <= 1'b0;
            r_scan_clk_en <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // start has priority over a coincident abort here
                    if (i_start) begin
                        r_state     <= S_LOAD;
                        r_busy      <= 1'b1;
                        r_err       <= 1'b0;
                        r_bits_left <= c_BITS_INIT;
                        r_cfg_ready <= 1'b1;
                        r_scan_en   <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (i_abort) begin
                        // any handshake in this cycle is dropped
                        r_state       <= S_IDLE;
                        r_err         <= 1'b1;
                        r_busy        <= 1'b0;
                        r_cfg_ready   <= 1'b0;
                        r_scan_en     <= 1'b0;
                        r_scan_clk_en <= 1'b0;
                        r_shreg       <= '0;
                    end else if (w_handshake) begin
                        r_state       <= S_SHIFT;
                        r_shreg       <= i_cfg_data;
                        r_word_bits   <= w_word_bits_init;
                        r_cfg_ready   <= 1'b0;
                        r_scan_clk_en <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (i_abort) begin
                        r_state       <= S_IDLE;
                        r_err         <= 1'b1;
                        r_busy        <= 1'b0;
                        r_cfg_ready   <= 1'b0;
                        r_scan_en     <= 1'b0;
                        r_scan_clk_en <= 1'b0;
                        r_shreg       <= '0;
                    end else begin
                        r_bits_left <= r_bits_left - c_BL_ONE;
                        r_word_bits <= r_word_bits - c_WB_ONE;
                        if (w_last_bit) begin
                            // unused upper bits of a partial word are dropped
                            r_state       <= S_DONE;
                            r_shreg       <= '0;
                            r_scan_en     <= 1'b0;
                            r_scan_clk_en <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                        end else if (w_word_end) begin
                            r_state       <= S_LOAD;
                            r_shreg       <= r_shreg >> 1;
                            r_scan_clk_en <= 1'b0;
                            r_cfg_ready   <= 1'b1;
                        end else begin
                            r_shreg <= r_shreg >> 1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cfg_ready   = r_cfg_ready;
    assign o_scan_en     = r_scan_en;
    assign o_scan_si     = r_shreg[0];
    assign o_scan_clk_en = r_scan_clk_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;

    // ------------------------------------------------------------------------
    // Readback: the tail bit is sampled on every shift edge, i.e. the bit
    // that leaves the chain on that edge. Words follow the input word
    // boundaries, so a partial final word comes out zero-padded.
    // ------------------------------------------------------------------------
`ifdef SCAN_READBACK_EN
    localparam int                c_RI_W   = $clog2(WORD_W);
    localparam logic [c_RI_W-1:0] c_RI_ONE = c_RI_W'(1);

    logic [WORD_W-1:0] r_rb_acc;
    logic [c_RI_W-1:0] r_rb_idx;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic [WORD_W-1:0] w_rb_next;
    logic              w_shift_step;

    assign w_shift_step = (r_state == S_SHIFT) && !i_abort;

    always_comb begin
        w_rb_next           = r_rb_acc;
        w_rb_next[r_rb_idx] = i_scan_so;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rb_acc   <= '0;
            r_rb_idx   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if ((r_state == S_SHIFT) && i_abort) begin
                // partial readback word is discarded on abort
                r_rb_acc <= '0;
                r_rb_idx <= '0;
            end else if (w_shift_step) begin
                if (w_last_bit || w_word_end) begin
                    r_rb_data  <= w_rb_next;
                    r_rb_valid <= 1'b1;
                    r_rb_acc   <= '0;
                    r_rb_idx   <= '0;
                end else begin
                    r_rb_acc <= w_rb_next;
                    r_rb_idx <= r_rb_idx + c_RI_ONE;
                end
            end
        end
    end

    assign o_rb_data  = r_rb_data;
    assign o_rb_valid = r_rb_valid;
`else
    // Tail input is not observed without readback.
    logic w_unused_scan_so;
    assign w_unused_scan_so = i_scan_so;

    assign o_rb_data  = '0;
    assign o_rb_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/scan_chain_loader.md
# scan_chain_loader

Sequencer that serially loads a configuration scan chain built from `scff` cells. It accepts parallel configuration words on a valid/ready stream and drives scan enable, scan data and a chain clock-enable so exactly `CHAIN_LEN` bits are shifted in, LSB first. It optionally reassembles the bits leaving the chain tail into readback words. It sits between the bitstream/config interface and the fabric scan chain.

## Interface
- `CHAIN_LEN`, 64: number of scan cells in the chain; must be ≥1.
- `WORD_W`, 8: configuration word width; must be ≥2.
- `clk` input 1: single clock, shared with the chain's gated clock source.
- `R` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle request to begin a load; ignored unless idle.
- `abort` input 1: terminate the load in progress.
- `cfg_data` input `WORD_W`: configuration word, bit 0 shifted first.
- `cfg_valid` input 1: `cfg_data` valid.
- `cfg_ready` output 1: word accepted when `cfg_valid && cfg_ready`.
- `scan_so` input 1: tail output of the chain (last cell `Q`).
- `scan_en` output 1: drives `E` of every cell (1 = shift `SI`).
- `scan_si` output 1: serial data into the chain head.
- `scan_clk_en` output 1: chain clock-gate enable; high only on shift cycles.
- `busy` output 1: load in progress.
- `done` output 1: one-cycle pulse on successful completion.
- `err` output 1: sticky abort flag; cleared by the next accepted `start`.
- `rb_data` output `WORD_W`: readback word (macro-dependent).
- `rb_valid` output 1: one-cycle readback strobe (macro-dependent).

## Operation
- Reset (`R`=0, asynchronous): state IDLE; all outputs 0; counters and shift register 0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: `start` → LOAD. Sets `busy`, clears `err`, and loads bits_left = `CHAIN_LEN`.
- LOAD: `cfg_ready`=1 and `scan_en`=1, with `scan_clk_en`=0 so the chain holds. On handshake, capture the word into the shift register, set word_bits = min(`WORD_W`, bits_left), then → SHIFT.
- SHIFT: `scan_en`=1, `scan_clk_en`=1, `scan_si` = shreg[0]. Each cycle: shreg >>= 1, word_bits−1, bits_left−1.
  - Last bit of a word with bits_left>1 → LOAD.
  - bits_left==1 → DONE.
- Partial last word: when `CHAIN_LEN` % `WORD_W` ≠ 0, only the low bits are shifted and the upper bits are discarded.
- DONE: `done`=1 for one cycle, `busy`=0, `scan_en`=0, then → IDLE.
- `abort` in LOAD or SHIFT → IDLE next cycle.
  - `err`=1; `scan_en`, `scan_clk_en`, `cfg_ready` and `busy` drop to 0; no `done`.
  - A handshake coincident with `abort` is discarded.
  - `abort` in IDLE or DONE has no effect.
- `start` while `busy` is ignored. `start` and `abort` in the same IDLE cycle: `start` wins.
- `scan_en` and `scan_clk_en` are registered outputs (glitch-free).

## Timing
- Handshake in cycle N: the first bit appears on `scan_si` with `scan_clk_en`=1 in cycle N+1. A full word occupies cycles N+1..N+`WORD_W`.
- Next `cfg_ready` is in cycle N+`WORD_W`+1. Peak throughput is one word per `WORD_W`+1 cycles.
- `done` pulses the cycle after the final shift cycle.
- Total load with zero-wait producer: 1 + ceil(`CHAIN_LEN`/`WORD_W`) × ... = 1 + `CHAIN_LEN` + ceil(`CHAIN_LEN`/`WORD_W`) cycles from `start` to `done`.
- Producer stalls (`cfg_valid`=0) hold LOAD indefinitely with the chain clock gated off.

## Configuration
- `SCAN_READBACK_EN` defined:
  - `scan_so` is sampled on every SHIFT cycle, i.e. the bit leaving the chain on that edge.
  - Samples are packed LSB first into `rb_data`.
  - `rb_valid` pulses the cycle after `WORD_W` samples, or after the final partial word, zero-padded in the high bits.
  - Abort discards the partial readback word.
- `SCAN_READBACK_EN` undefined: readback logic is absent; `rb_data`=0 and `rb_valid`=0 constantly.

## Test plan
- `CHAIN_LEN`=12, `WORD_W`=8, words 0xA5, 0x0C with `cfg_valid` held high → `scan_si` sequence 1,0,1,0,0,1,0,1,0,0,1,1. `scan_clk_en` high for exactly 12 cycles; `done` at cycle 15 after `start`.
- Same setup, `cfg_valid` dropped for 5 cycles between words → `scan_clk_en`=0 and `scan_en`=1 during the gap; same bit sequence; `done` is 5 cycles later.
- `abort` on the 3rd shift cycle of word 0 → next cycle `busy`=0, `scan_en`=0, `err`=1, no `done`. A following `start` clears `err`.
- `R` asserted mid-SHIFT → all outputs 0 immediately (asynchronously); after release the block is idle and a fresh load completes normally.
- `start` pulsed while `busy` → ignored; bit count and `done` timing unchanged.
- `SCAN_READBACK_EN` with a behavioural 12-cell `scff` chain preloaded to 0xF3C → `rb_data`=0x3C then 0x0F, each with a one-cycle `rb_valid`. A second load then reads back 0xA5, 0x0C.
